// File: rtl/bhargava_session_ctrl.sv
// Session controller between the UART byte stream and the bhargava core.
// Receive side assembles key and mode header, then forwards payload bytes
// into the core input FIFO. Transmit side drains the core output FIFO into
// uart_tx one byte at a time.
module bhargava_session_ctrl #(
  parameter int unsigned KEY_BYTES    = 8,
  parameter int unsigned IDLE_TIMEOUT = 2000000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  output logic [KEY_BYTES*8-1:0] key_out,
  output logic                   mode_out,
  output logic                   key_load,
  output logic [7:0]             fifo_wr_data,
  output logic                   fifo_wr,
  input  logic                   fifo_full,
  output logic                   fifo_rd,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_empty,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  output logic                   stream_end,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   done,
  output logic [1:0]             state_out
);

  localparam int unsigned KeyW  = KEY_BYTES * 8;
  localparam int unsigned BcntW = $clog2(KEY_BYTES + 1);

  typedef enum logic [1:0] {
    StKey  = 2'd0,
    StMode = 2'd1,
    StData = 2'd2,
    StEnd  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [KeyW-1:0]   key_q, key_d;
  logic              mode_q, mode_d;
  logic [BcntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              load_arm_q, load_arm_d;
  logic              key_load_q;
  logic              stream_end_q, stream_end_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;

  logic              rd_q, rd_d;
  logic              pending_q, pending_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              idle_expired;
  logic              wr_en;

  // The idle window closes on the IDLE_TIMEOUT-th consecutive quiet cycle.
  assign idle_expired = (idle_q == CNT_W'(IDLE_TIMEOUT - 1));

  // Receive FSM: header parsing, payload forwarding and session teardown.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    load_arm_d   = 1'b0;
    stream_end_d = stream_end_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;
    wr_en        = 1'b0;

    unique case (state_q)
      StKey: begin
        if (rx_parity_err) begin
          cnt_d  = '0;
          key_d  = '0;
          idle_d = '0;
        end else if (rx_valid) begin
          // First byte lands in the most significant byte lane.
          for (int i = 0; i < int'(KEY_BYTES); i++) begin
            if (cnt_q == BcntW'(i)) begin
              key_d[KeyW-1-8*i -: 8] = rx_data;
            end
          end
          cnt_d  = cnt_q + BcntW'(1);
          idle_d = '0;
          if (cnt_q == BcntW'(KEY_BYTES - 1)) begin
            state_d = StMode;
          end
        end else if (cnt_q != '0) begin
          if (idle_expired) begin
            cnt_d  = '0;
            key_d  = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + CNT_W'(1);
          end
        end
      end

      StMode: begin
        if (rx_parity_err) begin
          state_d = StKey;
          cnt_d   = '0;
          key_d   = '0;
          idle_d  = '0;
        end else if (rx_valid) begin
          mode_d     = rx_data[0];
          state_d    = StData;
          load_arm_d = 1'b1;
          idle_d     = '0;
        end else if (idle_expired) begin
          state_d = StKey;
          cnt_d   = '0;
          key_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end

      StData: begin
        if (rx_parity_err) begin
          state_d      = StEnd;
          stream_end_d = 1'b1;
        end else if (rx_valid) begin
          if (!fifo_full) begin
            wr_en = 1'b1;
          end else begin
            overflow_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end
          end
        end
      end

      StEnd: begin
        // Absorbing until reset.
      end

      default: begin
        state_d = StKey;
      end
    endcase
  end

  // Transmit drain: one outstanding read, then hold the byte until uart_tx takes it.
  always_comb begin
    fifo_rd   = !pending_q && !rd_q && !fifo_empty;
    tx_en     = pending_q && !tx_busy;
    rd_d      = fifo_rd;
    pending_d = pending_q;
    tx_data_d = tx_data_q;
    if (rd_q) begin
      tx_data_d = fifo_rd_data;
      pending_d = 1'b1;
    end else if (tx_en) begin
      pending_d = 1'b0;
    end
  end

  // Receive-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StKey;
      key_q        <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= '0;
      load_arm_q   <= 1'b0;
      key_load_q   <= 1'b0;
      stream_end_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      load_arm_q   <= load_arm_d;
      key_load_q   <= load_arm_q;
      stream_end_q <= stream_end_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  // Transmit-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= 1'b0;
      pending_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      rd_q      <= rd_d;
      pending_q <= pending_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign key_out      = key_q;
  assign mode_out     = mode_q;
  assign key_load     = key_load_q;
  assign fifo_wr      = wr_en;
  assign fifo_wr_data = rx_data;
  assign tx_data      = tx_data_q;
  assign stream_end   = stream_end_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_q;
  assign state_out    = state_q;
  assign done         = (state_q == StEnd) && fifo_empty && !pending_q && !rd_q && !tx_busy;

endmodule

// File: tb/tb_bhargava_session_ctrl.sv
// Bench for bhargava_session_ctrl: a behavioural model (header byte queue,
// flags, counters) is compared with the DUT every cycle, plus directed
// literal checks for the main scenarios.
module tb_bhargava_session_ctrl;

  localparam int KB = 8;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic [63:0] key_out;
  logic        mode_out;
  logic        key_load;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr;
  logic        fifo_full = 1'b0;
  logic        fifo_rd;
  logic [7:0]  fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy = 1'b0;
  logic        stream_end;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        done;
  logic [1:0]  state_out;

  bhargava_session_ctrl #(
    .KEY_BYTES   (KB),
    .IDLE_TIMEOUT(TO),
    .CNT_W       (24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .key_out      (key_out),
    .mode_out     (mode_out),
    .key_load     (key_load),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr      (fifo_wr),
    .fifo_full    (fifo_full),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_busy      (tx_busy),
    .stream_end   (stream_end),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .done         (done),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_hdr[$];  // header bytes received so far (key, then implicit mode phase)
  bit          m_in_data = 0, m_ended = 0, m_mode = 0;
  bit          m_arm = 0, m_load = 0, m_ovf = 0;
  int          m_idle = 0, m_drop = 0;
  bit          m_pend = 0, m_rdq = 0;
  logic [7:0]  m_txd = '0;
  // environment: core output FIFO contents and transmitter busy timer
  logic [7:0]  out_q[$];
  logic [7:0]  rd_stage = '0;
  int          busy_cnt = 0, busy_len = 0;
  bit          rd_now, txen_now;

  function automatic logic [63:0] m_key();
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < m_hdr.size(); i++) k[63-8*i -: 8] = m_hdr[i];
    return k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hdr.delete();
      m_in_data = 0; m_ended = 0; m_mode = 0; m_arm = 0; m_load = 0; m_ovf = 0;
      m_idle = 0; m_drop = 0; m_pend = 0; m_rdq = 0; m_txd = '0;
      out_q.delete();
      busy_cnt = 0;
    end else begin
      rd_now   = !m_pend && !m_rdq && !fifo_empty;
      txen_now = m_pend && !tx_busy;
      m_load = m_arm;
      m_arm  = 0;
      if (!m_in_data) begin
        if (rx_parity_err) begin
          m_hdr.delete();
          m_idle = 0;
        end else if (rx_valid) begin
          m_idle = 0;
          if (m_hdr.size() < KB) m_hdr.push_back(rx_data);
          else begin
            m_mode = rx_data[0];
            m_in_data = 1;
            m_arm = 1;
          end
        end else if (m_hdr.size() != 0) begin
          m_idle++;
          if (m_idle == TO) begin
            m_hdr.delete();
            m_idle = 0;
          end
        end
      end else if (!m_ended) begin
        if (rx_parity_err) m_ended = 1;
        else if (rx_valid && fifo_full) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (m_rdq) begin
        m_txd  = fifo_rd_data;
        m_pend = 1;
      end else if (txen_now) m_pend = 0;
      m_rdq = rd_now;
      if (rd_now) rd_stage = out_q.pop_front();
      if (busy_cnt > 0) busy_cnt--;
      if (txen_now) busy_cnt = busy_len;
    end
    #1;
    fifo_empty   = (out_q.size() == 0);
    fifo_rd_data = rd_stage;
    tx_busy      = (busy_cnt > 0);
  end

  // ---------------- per-cycle compare ----------------
  int         wr_seen = 0, kl_seen = 0;
  logic [7:0] txlog[$];
  logic [1:0] e_state;
  bit         e_wr, e_rd, e_txen, e_done;

  always @(negedge clk) begin
    if (chk_en) begin
      e_state = m_ended ? 2'd3 : m_in_data ? 2'd2 : (m_hdr.size() == KB) ? 2'd1 : 2'd0;
      e_wr    = m_in_data && !m_ended && rx_valid && !rx_parity_err && !fifo_full;
      e_rd    = !m_pend && !m_rdq && !fifo_empty;
      e_txen  = m_pend && !tx_busy;
      e_done  = m_ended && fifo_empty && !m_pend && !m_rdq && !tx_busy;
      chk("state_out", state_out, e_state);
      chk("key_out", key_out, m_key());
      chk("mode_out", mode_out, m_mode);
      chk("key_load", key_load, m_load);
      chk("fifo_wr", fifo_wr, e_wr);
      if (e_wr) chk("fifo_wr_data", fifo_wr_data, rx_data);
      chk("fifo_rd", fifo_rd, e_rd);
      chk("tx_en", tx_en, e_txen);
      chk("tx_data", tx_data, m_txd);
      chk("stream_end", stream_end, m_ended);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("done", done, e_done);
    end
    if (fifo_wr) wr_seen++;
    if (key_load) kl_seen++;
    if (tx_en) txlog.push_back(tx_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_in(input bit v, input logic [7:0] d, input bit p);
    rx_valid = v;
    rx_data = d;
    rx_parity_err = p;
    @(posedge clk);
    #1;
    rx_valid = 0;
    rx_parity_err = 0;
  endtask

  task automatic send(input logic [7:0] d);
    step_in(1, d, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_in(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    rx_valid = 0;
    rx_parity_err = 0;
    fifo_full = 0;
    #2;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int w0, k0, n;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    // reset state
    chk("rst_state", state_out, 0);
    chk("rst_key", key_out, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_txdata", tx_data, 0);

    // key + mode
    for (int i = 1; i <= 8; i++) send(8'(i));
    k0 = kl_seen;
    send(8'h01);
    @(negedge clk);
    chk("kl_plus1", key_load, 0);
    chk("state_plus1", state_out, 2);
    @(negedge clk);
    chk("kl_plus2", key_load, 1);
    @(posedge clk); #1;
    idle(2);
    chk("key_lit", key_out, 64'h0102030405060708);
    chk("mode_lit", mode_out, 1);
    chk("state_data", state_out, 2);
    chk("kl_count", kl_seen - k0, 1);

    // payload with overflow on bytes 2-3
    w0 = wr_seen;
    send(8'hA0);
    fifo_full = 1;
    send(8'hA1);
    send(8'hA2);
    fifo_full = 0;
    send(8'hA3);
    send(8'hA4);
    chk("wr_count", wr_seen - w0, 3);
    chk("drop_lit", drop_cnt, 2);
    chk("ovf_lit", overflow, 1);

    // parity error ends the stream while output FIFO drains
    busy_len = 10;
    txlog.delete();
    out_q.push_back(8'hAA);
    out_q.push_back(8'hBB);
    out_q.push_back(8'hCC);
    w0 = wr_seen;
    step_in(1, 8'h55, 1);
    chk("end_state", state_out, 3);
    chk("end_sticky", stream_end, 1);
    send(8'h66);
    send(8'h67);
    chk("end_no_wr", wr_seen - w0, 0);
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_lit", done, 1);
    chk("tx_count", txlog.size(), 3);
    if (txlog.size() == 3) begin
      chk("tx0", txlog[0], 8'hAA);
      chk("tx1", txlog[1], 8'hBB);
      chk("tx2", txlog[2], 8'hCC);
    end

    // idle boundary: TO-1 quiet cycles keep the partial header
    do_reset();
    busy_len = 0;
    send(8'hE1); send(8'hE2); send(8'hE3);
    idle(TO - 1);
    for (int i = 4; i <= 8; i++) send(8'(i));
    chk("no_to_state", state_out, 1);
    chk("no_to_key", key_out, 64'hE1E2E30405060708);
    idle(TO);
    chk("to_mode_state", state_out, 0);
    chk("to_mode_key", key_out, 0);

    // timeout discards a partial key
    send(8'hE1); send(8'hE2); send(8'hE3);
    idle(TO);
    for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
    send(8'h00);
    idle(3);
    chk("to_key", key_out, 64'h1112131415161718);
    chk("to_mode", mode_out, 0);
    chk("to_state", state_out, 2);

    // reset while a byte is pending for transmit
    busy_len = 10;
    out_q.push_back(8'h77);
    n = 0;
    while (!m_pend && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pend_reached", m_pend, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_txen", tx_en, 0);
    chk("arst_txdata", tx_data, 0);
    chk("arst_key", key_out, 0);
    chk("arst_state", state_out, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_kl", key_load, 0);
    @(posedge clk); #1;
    rst_n = 1;
    busy_len = 0;
    for (int i = 0; i < 8; i++) send(8'(8'h21 + i));
    send(8'h01);
    idle(2);
    chk("rekey", key_out, 64'h2122232425262728);
    chk("rekey_state", state_out, 2);

    // randomized sessions
    for (int it = 0; it < 6; it++) begin
      do_reset();
      busy_len = $urandom_range(0, 5);
      for (int c = 0; c < 1500; c++) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        if (($urandom_range(0, 9) == 0) && out_q.size() < 4) out_q.push_back(8'($urandom));
        if ($urandom_range(0, 199) == 0) begin
          idle(TO - 2 + $urandom_range(0, 4));
        end else begin
          b = 8'($urandom);
          step_in($urandom_range(0, 99) < 45, b, $urandom_range(0, 299) == 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
